// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32I constants and helpers for the fetch stage.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [31:0]     NOP_INST         = 32'h0000_0013;
    localparam logic [1:0]      INST_ALIGN_MASK  = 2'b11;
    localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [XLEN-1:0] word_t;

    function automatic logic is_misaligned(input word_t pc);
        return |(pc[1:0] & INST_ALIGN_MASK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Brief    : Small synchronous {data, pc} FIFO with flush; data storage optional.
// Revision : 1.0
// ============================================================================
module ifetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter bit HAS_DATA = 1'b1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  word_t            push_data,
    input  word_t            push_pc,
    input  logic             pop,
    output word_t            head_data,
    output word_t            head_pc,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    word_t            r_pc_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop in the same cycle frees the slot, so a full queue still accepts a push.
    assign w_pop  = pop & (r_count != '0);
    assign w_push = push & ((r_count != CNT_W'(DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_pc_mem[r_wr_ptr] <= push_pc;
    end

    generate
        if (HAS_DATA) begin : g_data
            word_t r_data_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (w_push) r_data_mem[r_wr_ptr] <= push_data;
            end
            assign head_data = r_data_mem[r_rd_ptr];
        end else begin : g_no_data
            logic w_unused_data;
            assign w_unused_data = ^push_data;
            assign head_data     = '0;
        end
    endgenerate

    assign head_pc = r_pc_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : RV32I fetch stage: PC, credit-limited imem requests, in-order queue.
// Revision : 1.0
// ============================================================================
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    output logic        fetch_misalign
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);

    word_t            r_pc;
    logic [OUT_W-1:0] r_outstanding;
    logic [OUT_W-1:0] r_discard;
    logic             r_misalign;

    logic [OUT_W-1:0] w_outstanding_next;
    logic [SUM_W-1:0] w_live;
    logic             w_req_fire;
    logic             w_rsp_fire;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    word_t            w_head_inst;
    word_t            w_head_pc;
    word_t            w_tag_pc;
    word_t            w_unused_tag_data;
    logic [OUT_W-1:0] w_unused_tag_count;

    // Live (non-discarded) responses plus queued entries must fit the queue.
    assign w_live = SUM_W'(r_outstanding - r_discard) + SUM_W'(w_count);

    assign imem_req_valid = !rst && !r_misalign
                          && (r_outstanding < OUT_W'(MAX_OUTSTANDING))
                          && (w_live < SUM_W'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;

    assign w_req_fire         = imem_req_valid & imem_req_ready;
    assign w_rsp_fire         = imem_rsp_valid;
    assign w_outstanding_next = r_outstanding + OUT_W'(w_req_fire) - OUT_W'(w_rsp_fire);
    assign w_push             = w_rsp_fire & (r_discard == '0) & !redirect_valid;
    assign w_pop              = fetch_valid & fetch_ready & !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_pc       <= redirect_pc;
                r_discard  <= w_outstanding_next;
                r_misalign <= is_misaligned(redirect_pc);
            end else begin
                if (w_req_fire) r_pc <= r_pc + 32'd4;
                if (w_rsp_fire && (r_discard != '0)) r_discard <= r_discard - OUT_W'(1);
            end
        end
    end

    // PC tags track every request in flight, stale ones included, so never flushed.
    ifetch_fifo #(
        .DEPTH    (MAX_OUTSTANDING),
        .HAS_DATA (1'b0),
        .CNT_W    (OUT_W)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (w_req_fire),
        .push_data ('0),
        .push_pc   (r_pc),
        .pop       (w_rsp_fire),
        .head_data (w_unused_tag_data),
        .head_pc   (w_tag_pc),
        .count     (w_unused_tag_count)
    );

    ifetch_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .HAS_DATA (1'b1),
        .CNT_W    (CNT_W)
    ) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (imem_rsp_data),
        .push_pc   (w_tag_pc),
        .pop       (w_pop),
        .head_data (w_head_inst),
        .head_pc   (w_head_pc),
        .count     (w_count)
    );

    assign fetch_valid    = !rst && (w_count != '0);
    assign fetch_inst     = fetch_valid ? w_head_inst : NOP_INST;
    assign fetch_pc       = fetch_valid ? w_head_pc : '0;
    assign fetch_misalign = r_misalign;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (r_outstanding != '0));

endmodule
`default_nettype wire
